// File: rtl/sc_regwr_pkg.sv
// Shared constants, entry type, controller-state encoding and one-cold decoder
// for the register write-back controller.
package sc_regwr_pkg;

  localparam int DATAWIDTH_BUS = 32;
  localparam int REGADDR_WIDTH = 5;
  localparam int NUM_REGS      = 1 << REGADDR_WIDTH;
  localparam int FIFO_DEPTH    = 4;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

  localparam logic [NUM_REGS-1:0] ALL_WR_IDLE = {NUM_REGS{1'b1}};
  localparam logic [CNT_W-1:0]    DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [REGADDR_WIDTH-1:0] addr;
    logic [DATAWIDTH_BUS-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } ctrl_state_t;

  function automatic logic [NUM_REGS-1:0] addr_to_onecold(input logic [REGADDR_WIDTH-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = ALL_WR_IDLE;
    v[addr] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sc_regwr_fifo.sv
// In-order request buffer: FIFO_DEPTH entries, naturally wrapping pointers,
// async active-low reset. Push when full and pop when empty are ignored.
module sc_regwr_fifo
  import sc_regwr_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  entry_t           wr_entry_i,
  input  logic             pop_i,
  output entry_t           rd_entry_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == DEPTH_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rd_entry_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
  end

endmodule

// File: rtl/sc_reg_write_ctrl.sv
// Write-back controller feeding the register bank: valid/ready intake, FIFO,
// one-cold strobe drive. Optional feature: `SC_REGWRCTRL_R0_PROTECT_EN.
module sc_reg_write_ctrl
  import sc_regwr_pkg::*;
(
  input  logic                     SC_RegWRCTRL_CLOCK_50,
  input  logic                     SC_RegWRCTRL_RESET_InLow,
  input  logic                     SC_RegWRCTRL_wrValid_InHigh,
  output logic                     SC_RegWRCTRL_wrReady_OutHigh,
  input  logic [REGADDR_WIDTH-1:0] SC_RegWRCTRL_wrAddr_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegWRCTRL_wrData_InBUS,
  input  logic                     SC_RegWRCTRL_Stall_InHigh,
  output logic [NUM_REGS-1:0]      SC_RegWRCTRL_Write_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SC_RegWRCTRL_data_OutBUS,
  output logic                     SC_RegWRCTRL_Pending_OutHigh,
  output logic [CNT_W-1:0]         SC_RegWRCTRL_Count_OutBUS
);

  // Handshake: a request transfers on the rising edge where valid and ready
  // are both high; ready depends only on registered state, never on valid.
  ctrl_state_t         state_q, state_d;
  entry_t              head, in_entry;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                accept, push, pop;
  logic [NUM_REGS-1:0] write_q, write_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;

  assign accept        = SC_RegWRCTRL_wrValid_InHigh & SC_RegWRCTRL_wrReady_OutHigh;
  assign in_entry.addr = SC_RegWRCTRL_wrAddr_InBUS;
  assign in_entry.data = SC_RegWRCTRL_wrData_InBUS;

`ifdef SC_REGWRCTRL_R0_PROTECT_EN
  // Register 0 is hardwired zero: its requests are acknowledged and dropped.
  assign push = accept & ~fifo_full & (SC_RegWRCTRL_wrAddr_InBUS != '0);
`else
  assign push = accept & ~fifo_full;
`endif

  assign pop = ~fifo_empty & ~SC_RegWRCTRL_Stall_InHigh;

  sc_regwr_fifo u_fifo (
    .clk_i      (SC_RegWRCTRL_CLOCK_50),
    .rst_ni     (SC_RegWRCTRL_RESET_InLow),
    .push_i     (push),
    .wr_entry_i (in_entry),
    .pop_i      (pop),
    .rd_entry_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge SC_RegWRCTRL_CLOCK_50 or negedge SC_RegWRCTRL_RESET_InLow) begin
    if (!SC_RegWRCTRL_RESET_InLow) state_q <= ST_EMPTY;
    else                           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (push) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (push && !pop && fifo_count == DEPTH_CNT - 1'b1) state_d = ST_FULL;
        else if (pop && !push && fifo_count == CNT_W'(1))   state_d = ST_EMPTY;
      end
      ST_FULL:   if (pop && !push) state_d = ST_ACTIVE;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    SC_RegWRCTRL_wrReady_OutHigh = (state_q != ST_FULL);
    SC_RegWRCTRL_Pending_OutHigh = (state_q != ST_EMPTY);
  end

  always_comb begin
    write_d = ALL_WR_IDLE;
    data_d  = data_q;
    if (pop) begin
      write_d = addr_to_onecold(head.addr);
      data_d  = head.data;
    end
  end

  always_ff @(posedge SC_RegWRCTRL_CLOCK_50 or negedge SC_RegWRCTRL_RESET_InLow) begin
    if (!SC_RegWRCTRL_RESET_InLow) begin
      write_q <= ALL_WR_IDLE;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      data_q  <= data_d;
    end
  end

  assign SC_RegWRCTRL_Write_OutLow = write_q;
  assign SC_RegWRCTRL_data_OutBUS  = data_q;
  assign SC_RegWRCTRL_Count_OutBUS = fifo_count;

endmodule

// File: tb/tb_sc_reg_write_ctrl.sv
// Directed + random bench for sc_reg_write_ctrl with a queue-based reference
// model and a behavioural register bank driven by the strobes.
module tb_sc_reg_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        stall;
  logic [31:0] wr_n;
  logic [31:0] bus;
  logic        pending;
  logic [2:0]  count;

  logic [36:0] exp_q[$];
  logic [31:0] exp_write;
  logic [31:0] exp_data;
  logic [31:0] bank   [32];
  logic [31:0] bank_m [32];
  int          n_cmp;
  int          n_fail;

`ifdef SC_REGWRCTRL_R0_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  sc_reg_write_ctrl dut (
    .SC_RegWRCTRL_CLOCK_50        (clk),
    .SC_RegWRCTRL_RESET_InLow     (rst_n),
    .SC_RegWRCTRL_wrValid_InHigh  (valid),
    .SC_RegWRCTRL_wrReady_OutHigh (ready),
    .SC_RegWRCTRL_wrAddr_InBUS    (addr),
    .SC_RegWRCTRL_wrData_InBUS    (data),
    .SC_RegWRCTRL_Stall_InHigh    (stall),
    .SC_RegWRCTRL_Write_OutLow    (wr_n),
    .SC_RegWRCTRL_data_OutBUS     (bus),
    .SC_RegWRCTRL_Pending_OutHigh (pending),
    .SC_RegWRCTRL_Count_OutBUS    (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the register bank the controller drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) if (!wr_n[i]) bank[i] <= bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("count", {29'd0, count}, exp_q.size());
    check("pending", {31'd0, pending}, {31'd0, exp_q.size() != 0});
    check("ready", {31'd0, ready}, {31'd0, exp_q.size() < 4});
    check("write_n", wr_n, exp_write);
    check("data", bus, exp_data);
  endtask

  // One clock: model the edge from the inputs present at it, then check.
  task automatic step();
    logic [36:0] e;
    bit          rdy;
    @(posedge clk);
    for (int i = 0; i < 32; i++) if (!exp_write[i]) bank_m[i] = exp_data;
    rdy = (exp_q.size() < 4);
    if (exp_q.size() > 0 && !stall) begin
      e         = exp_q.pop_front();
      exp_write = ~(32'd1 << e[36:32]);
      exp_data  = e[31:0];
    end else begin
      exp_write = '1;
    end
    if (valid && rdy && !(PROTECT && addr == 5'd0)) exp_q.push_back({addr, data});
    #1;
    check_outputs();
  endtask

  // Called one time unit after an edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_write = '1;
    exp_data  = '0;
    for (int i = 0; i < 32; i++) bank_m[i] = '0;
    check("rst_write_n", wr_n, 32'hFFFF_FFFF);
    check("rst_data", bus, 32'h0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_bank();
    for (int i = 0; i < 32; i++) check("bank", bank[i], bank_m[i]);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1; valid = 1'b0; addr = '0; data = '0; stall = 1'b0;
    exp_write = '1; exp_data = '0;

    // reset out of power-up, then ready on the first edge after release
    do_reset();
    step();
    check("ready_after_rst", {31'd0, ready}, 32'd1);

    // single write: accepted at edge N, strobe during cycle N+1 only
    valid = 1'b1; addr = 5'd5; data = 32'hDEAD_BEEF;
    step();
    valid = 1'b0;
    step();
    check("single_strobe", wr_n, ~32'h20);
    check("single_data", bus, 32'hDEAD_BEEF);
    step();
    check("single_idle", wr_n, 32'hFFFF_FFFF);
    check("single_hold", bus, 32'hDEAD_BEEF);
    step();
    check("bank5", bank[5], 32'hDEAD_BEEF);

    // fill while stalled; fifth request is held off by ready
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      valid = 1'b1; addr = 5'(i); data = $urandom;
      step();
      if (i == 4) begin
        check("full_ready", {31'd0, ready}, 32'd0);
        check("full_count", {29'd0, count}, 32'd4);
      end
    end
    step();
    check("held_count", {29'd0, count}, 32'd4);
    stall = 1'b0;
    step();
    check("drain1", wr_n, ~32'h2);
    step();
    check("drain2", wr_n, ~32'h4);
    valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // WAW to register 7
    valid = 1'b1; addr = 5'd7; data = 32'd1;
    step();
    data = 32'd2;
    step();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("waw_bank7", bank[7], 32'd2);

    // push and pop together at Count=2 for three pointer laps
    stall = 1'b1; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr = 5'($urandom_range(1, 31)); data = $urandom;
      step();
    end
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      addr = 5'($urandom_range(1, 31)); data = $urandom;
      step();
      check("pp_count", {29'd0, count}, 32'd2);
    end
    valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_bank();

    // register 0 request
    valid = 1'b1; addr = 5'd0; data = 32'h1234_5678;
    step();
    valid = 1'b0;
    check("r0_count", {29'd0, count}, PROTECT ? 32'd0 : 32'd1);
    step();
    check("r0_bit", {31'd0, wr_n[0]}, PROTECT ? 32'd1 : 32'd0);
    step();

    // reset mid-drain with Count=3
    stall = 1'b1; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 5'($urandom_range(1, 31)); data = $urandom;
      step();
    end
    valid = 1'b0; stall = 1'b0;
    step();
    check("pre_rst_count", {29'd0, count}, 32'd3);
    do_reset();
    step();
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check_bank();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      addr  = 5'($urandom_range(0, 31));
      data  = $urandom;
      step();
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_bank();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
